// File: rtl/id_ctrl_pipe_pkg.sv
// -----------------------------------------------------------------------------
// id_ctrl_pipe_pkg
// Shared opcode, ALU-command and branch-condition encodings for the MIPS
// pipeline, plus the control bundle carried from ID into the ID/EX register.
// No ports; imported by the decoder, the interface and the pipe top.
// -----------------------------------------------------------------------------
package id_ctrl_pipe_pkg;

   localparam int OPC_W = 6;
   localparam int EXE_W = 4;

   // Opcodes
   localparam logic [OPC_W-1:0] OP_ADD  = 6'b000001;
   localparam logic [OPC_W-1:0] OP_SUB  = 6'b000011;
   localparam logic [OPC_W-1:0] OP_AND  = 6'b000101;
   localparam logic [OPC_W-1:0] OP_OR   = 6'b000110;
   localparam logic [OPC_W-1:0] OP_NOR  = 6'b000111;
   localparam logic [OPC_W-1:0] OP_XOR  = 6'b001000;
   localparam logic [OPC_W-1:0] OP_SLT  = 6'b001001;
   localparam logic [OPC_W-1:0] OP_SLL  = 6'b001010;
   localparam logic [OPC_W-1:0] OP_SRL  = 6'b001011;
   localparam logic [OPC_W-1:0] OP_MUL  = 6'b001101;
   localparam logic [OPC_W-1:0] OP_ADDI = 6'b100000;
   localparam logic [OPC_W-1:0] OP_SUBI = 6'b100001;
   localparam logic [OPC_W-1:0] OP_LD   = 6'b100100;
   localparam logic [OPC_W-1:0] OP_ST   = 6'b100101;
   localparam logic [OPC_W-1:0] OP_BEZ  = 6'b101000;
   localparam logic [OPC_W-1:0] OP_BNE  = 6'b101001;
   localparam logic [OPC_W-1:0] OP_JMP  = 6'b101010;

   // ALU commands
   localparam logic [EXE_W-1:0] EXE_ADD          = 4'b0000;
   localparam logic [EXE_W-1:0] EXE_SUB          = 4'b0010;
   localparam logic [EXE_W-1:0] EXE_AND          = 4'b0100;
   localparam logic [EXE_W-1:0] EXE_OR           = 4'b0101;
   localparam logic [EXE_W-1:0] EXE_NOR          = 4'b0110;
   localparam logic [EXE_W-1:0] EXE_XOR          = 4'b0111;
   localparam logic [EXE_W-1:0] EXE_SLL          = 4'b1000;
   localparam logic [EXE_W-1:0] EXE_SRL          = 4'b1001;
   localparam logic [EXE_W-1:0] EXE_MUL          = 4'b1010;
   localparam logic [EXE_W-1:0] EXE_SLT          = 4'b1011;
   localparam logic [EXE_W-1:0] EXE_NO_OPERATION = 4'b1111;

   // Branch conditions
   localparam logic [1:0] COND_BNE  = 2'b01;
   localparam logic [1:0] COND_JUMP = 2'b10;
   localparam logic [1:0] COND_BEZ  = 2'b11;

   // Everything the ID/EX register hands to EX/MEM/WB (stall_req is FSM state
   // and lives outside the bundle).
   typedef struct packed {
      logic             branch_en;
      logic [EXE_W-1:0] exe_cmd;
      logic [1:0]       branch_cmd;
      logic             is_imm;
      logic             st_or_bne;
      logic             wb_en;
      logic             mem_read_en;
      logic             mem_write_en;
      logic             mul_start;
      logic             illegal_op;
   } ctrl_t;

   // All-zero bundle carrying only an ALU command.
   function automatic ctrl_t ctrl_exe(input logic [EXE_W-1:0] cmd);
      ctrl_t c;
      c         = '0;
      c.exe_cmd = cmd;
      return c;
   endfunction

endpackage

// File: rtl/id_ctrl_pipe_if.sv
// -----------------------------------------------------------------------------
// id_ctrl_pipe_if
// Bundles the IF/ID-side inputs (opcode, hazard_detected, flush) and every
// registered control output of the ID stage.
//   master : drives opcode/hazard_detected/flush, receives controls
//   slave  : the control pipe itself
// -----------------------------------------------------------------------------
interface id_ctrl_pipe_if #(
   parameter int OP_CODE_LEN = id_ctrl_pipe_pkg::OPC_W,
   parameter int EXE_CMD_LEN = id_ctrl_pipe_pkg::EXE_W
);
   logic [OP_CODE_LEN-1:0] opcode;
   logic                   hazard_detected;
   logic                   flush;

   logic                   Branch_En;
   logic [EXE_CMD_LEN-1:0] EXE_CMD;
   logic [1:0]             Branch_CMD;
   logic                   is_imm;
   logic                   ST_or_BNE;
   logic                   WB_EN;
   logic                   Mem_Read_EN;
   logic                   Mem_Write_EN;
   logic                   mul_start;
   logic                   stall_req;
   logic                   illegal_op;

   modport master (
      output opcode, hazard_detected, flush,
      input  Branch_En, EXE_CMD, Branch_CMD, is_imm, ST_or_BNE, WB_EN,
             Mem_Read_EN, Mem_Write_EN, mul_start, stall_req, illegal_op
   );

   modport slave (
      input  opcode, hazard_detected, flush,
      output Branch_En, EXE_CMD, Branch_CMD, is_imm, ST_or_BNE, WB_EN,
             Mem_Read_EN, Mem_Write_EN, mul_start, stall_req, illegal_op
   );
endinterface

// File: rtl/id_ctrl_pipe_ctrl_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
// Purely combinational opcode -> control bundle decoder.
//   opcode_i     : opcode from IF/ID
//   ctrl_o       : decoded bundle (bubble with illegal_op set if undecodable)
//   is_mul_o     : opcode is OP_MUL; the pipe's FSM sequences it
//   is_illegal_o : opcode is not in the table
// -----------------------------------------------------------------------------
module ctrl_decode
   import id_ctrl_pipe_pkg::*;
#(
   parameter int OP_CODE_LEN = OPC_W
) (
   input  logic [OP_CODE_LEN-1:0] opcode_i,
   output ctrl_t                  ctrl_o,
   output logic                   is_mul_o,
   output logic                   is_illegal_o
);

   always_comb begin
      ctrl_o       = '0;
      is_mul_o     = 1'b0;
      is_illegal_o = 1'b0;
      case (opcode_i)
         OP_ADD: begin ctrl_o = ctrl_exe(EXE_ADD); ctrl_o.wb_en = 1'b1; end
         OP_SUB: begin ctrl_o = ctrl_exe(EXE_SUB); ctrl_o.wb_en = 1'b1; end
         OP_AND: begin ctrl_o = ctrl_exe(EXE_AND); ctrl_o.wb_en = 1'b1; end
         OP_OR:  begin ctrl_o = ctrl_exe(EXE_OR);  ctrl_o.wb_en = 1'b1; end
         OP_XOR: begin ctrl_o = ctrl_exe(EXE_XOR); ctrl_o.wb_en = 1'b1; end
         OP_NOR: begin ctrl_o = ctrl_exe(EXE_NOR); ctrl_o.wb_en = 1'b1; end
         OP_SLL: begin ctrl_o = ctrl_exe(EXE_SLL); ctrl_o.wb_en = 1'b1; end
         OP_SRL: begin ctrl_o = ctrl_exe(EXE_SRL); ctrl_o.wb_en = 1'b1; end
         OP_SLT: begin ctrl_o = ctrl_exe(EXE_SLT); ctrl_o.wb_en = 1'b1; end
         OP_ADDI, OP_SUBI: begin
            ctrl_o        = ctrl_exe(EXE_ADD);
            ctrl_o.wb_en  = 1'b1;
            ctrl_o.is_imm = 1'b1;
         end
         OP_LD: begin
            ctrl_o             = ctrl_exe(EXE_ADD);
            ctrl_o.wb_en       = 1'b1;
            ctrl_o.is_imm      = 1'b1;
            ctrl_o.st_or_bne   = 1'b1;
            ctrl_o.mem_read_en = 1'b1;
         end
         OP_ST: begin
            ctrl_o              = ctrl_exe(EXE_ADD);
            ctrl_o.is_imm       = 1'b1;
            ctrl_o.st_or_bne    = 1'b1;
            ctrl_o.mem_write_en = 1'b1;
         end
         OP_BEZ, OP_BNE, OP_JMP: begin
            ctrl_o           = ctrl_exe(EXE_NO_OPERATION);
            ctrl_o.is_imm    = 1'b1;
            ctrl_o.branch_en = 1'b1;
            if (opcode_i == OP_BEZ) begin
               ctrl_o.branch_cmd = COND_BEZ;
            end else if (opcode_i == OP_BNE) begin
               ctrl_o.branch_cmd = COND_BNE;
               ctrl_o.st_or_bne  = 1'b1;
            end else begin
               ctrl_o.branch_cmd = COND_JUMP;
            end
         end
         // The bundle stays zero: the FSM builds the MUL slots itself.
         OP_MUL: is_mul_o = 1'b1;
         default: begin
            is_illegal_o      = 1'b1;
            ctrl_o.illegal_op = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/id_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// id_ctrl_pipe
// Registered ID-stage controller: decode feeds the ID/EX control register
// directly (one cycle opcode->controls). Handles hazard/flush bubbles and
// sequences OP_MUL over MUL_CYCLES slots while holding the front end.
//   clk, rst_n : clock, async active-low reset
//   bus        : id_ctrl_pipe_if.slave -- opcode/hazard_detected/flush in,
//                all registered control outputs (incl. stall_req) out
// -----------------------------------------------------------------------------
module id_ctrl_pipe
   import id_ctrl_pipe_pkg::*;
#(
   parameter int OP_CODE_LEN = OPC_W,
   parameter int EXE_CMD_LEN = EXE_W,
   parameter int MUL_CYCLES  = 4      // legal 2..16
) (
   input  logic          clk,
   input  logic          rst_n,
   id_ctrl_pipe_if.slave bus
);

   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_MUL_BUSY = 1'b1;

   localparam int              CNT_W    = $clog2(MUL_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 2);

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ctrl_t            ctrl_q, ctrl_d;

   ctrl_t dec_ctrl;
   logic  dec_is_mul;
   logic  dec_is_illegal;

   ctrl_decode #(.OP_CODE_LEN(OP_CODE_LEN)) u_dec (
      .opcode_i     (bus.opcode),
      .ctrl_o       (dec_ctrl),
      .is_mul_o     (dec_is_mul),
      .is_illegal_o (dec_is_illegal)
   );

   // Priority: flush > MUL_BUSY > hazard > decode. ctrl_d defaults to bubble.
   always_comb begin
      ctrl_d  = '0;
      state_d = state_q;
      cnt_d   = cnt_q;
      if (bus.flush) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (state_q == ST_MUL_BUSY) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
         end else begin
            ctrl_d       = ctrl_exe(EXE_MUL);
            ctrl_d.wb_en = 1'b1;
            state_d      = ST_IDLE;
         end
      end else if (bus.hazard_detected) begin
         ctrl_d = '0;
      end else if (dec_is_mul) begin
         ctrl_d           = ctrl_exe(EXE_MUL);
         ctrl_d.mul_start = 1'b1;
         cnt_d            = CNT_LOAD;
         state_d          = ST_MUL_BUSY;
      end else begin
         // dec_ctrl already carries illegal_op for undecodable opcodes.
         ctrl_d = dec_ctrl;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign bus.Branch_En    = ctrl_q.branch_en;
   assign bus.EXE_CMD      = EXE_CMD_LEN'(ctrl_q.exe_cmd);
   assign bus.Branch_CMD   = ctrl_q.branch_cmd;
   assign bus.is_imm       = ctrl_q.is_imm;
   assign bus.ST_or_BNE    = ctrl_q.st_or_bne;
   assign bus.WB_EN        = ctrl_q.wb_en;
   assign bus.Mem_Read_EN  = ctrl_q.mem_read_en;
   assign bus.Mem_Write_EN = ctrl_q.mem_write_en;
   assign bus.mul_start    = ctrl_q.mul_start;
   assign bus.illegal_op   = ctrl_q.illegal_op;
   // State bit is itself a flop, so stall_req is a registered output.
   assign bus.stall_req    = (state_q == ST_MUL_BUSY);

   // Illegal flag is folded into dec_ctrl; the separate strobe is unused here.
   logic unused_ok;
   assign unused_ok = dec_is_illegal;

endmodule

// File: tb/tb_id_ctrl_pipe.sv
module tb_id_ctrl_pipe;
   import id_ctrl_pipe_pkg::*;

   typedef struct packed {
      ctrl_t c;
      logic  stall;
   } exp_t;

   localparam logic [7:0] F_BE = 8'h80, F_IMM = 8'h40, F_SB = 8'h20, F_WB = 8'h10,
                          F_MR = 8'h08, F_MW  = 8'h04, F_MS = 8'h02, F_IL = 8'h01;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [5:0] opcode = '0;
   logic hazard = 1'b0;
   logic flush = 1'b0;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   exp_t obs4, obs2;

   always #5 clk = ~clk;

   id_ctrl_pipe_if if4 ();
   id_ctrl_pipe_if if2 ();
   assign if4.opcode = opcode; assign if4.hazard_detected = hazard; assign if4.flush = flush;
   assign if2.opcode = opcode; assign if2.hazard_detected = hazard; assign if2.flush = flush;

   id_ctrl_pipe #(.MUL_CYCLES(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
   id_ctrl_pipe #(.MUL_CYCLES(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   assign obs4 = {if4.Branch_En, if4.EXE_CMD, if4.Branch_CMD, if4.is_imm, if4.ST_or_BNE,
                  if4.WB_EN, if4.Mem_Read_EN, if4.Mem_Write_EN, if4.mul_start,
                  if4.illegal_op, if4.stall_req};
   assign obs2 = {if2.Branch_En, if2.EXE_CMD, if2.Branch_CMD, if2.is_imm, if2.ST_or_BNE,
                  if2.WB_EN, if2.Mem_Read_EN, if2.Mem_Write_EN, if2.mul_start,
                  if2.illegal_op, if2.stall_req};

   function automatic exp_t mk(input logic [3:0] exe, input logic [7:0] f,
                               input logic [1:0] bc, input logic stall);
      exp_t e;
      e = '0;
      e.c.exe_cmd      = exe;
      e.c.branch_cmd   = bc;
      e.c.branch_en    = f[7];
      e.c.is_imm       = f[6];
      e.c.st_or_bne    = f[5];
      e.c.wb_en        = f[4];
      e.c.mem_read_en  = f[3];
      e.c.mem_write_en = f[2];
      e.c.mul_start    = f[1];
      e.c.illegal_op   = f[0];
      e.stall          = stall;
      return e;
   endfunction

   task automatic test_reset();
      exp_t e;
      opcode = OP_ADD;
      sb.push_back(mk(EXE_ADD, F_WB, 2'b00, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (obs4 !== e) begin errors++; $display("FAIL reset_pre: got %h want %h", obs4, e); end
      // assert reset mid-cycle with LD presented
      #2; opcode = OP_LD; rst_n = 1'b0; #1;
      checks++;
      if (obs4 !== '0) begin errors++; $display("FAIL reset_async4: got %h want 0", obs4); end
      checks++;
      if (obs2 !== '0) begin errors++; $display("FAIL reset_async2: got %h want 0", obs2); end
      @(posedge clk); #1;
      checks++;
      if (obs4 !== '0) begin errors++; $display("FAIL reset_hold: got %h want 0", obs4); end
      rst_n = 1'b1;
      sb.push_back(mk(EXE_ADD, F_WB | F_IMM | F_SB | F_MR, 2'b00, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if (obs4 !== e) begin errors++; $display("FAIL reset_ld: got %h want %h", obs4, e); end
   endtask

   task automatic test_hazard_flush();
      logic hz[3] = '{1'b1, 1'b1, 1'b0};
      logic fl[3] = '{1'b0, 1'b1, 1'b0};
      exp_t e;
      sb.push_back('0);
      sb.push_back('0);
      sb.push_back(mk(EXE_ADD, F_IMM | F_SB | F_MW, 2'b00, 1'b0));
      for (int i = 0; i < 3; i++) begin
         opcode = OP_ST; hazard = hz[i]; flush = fl[i];
         @(posedge clk); #1;
         e = sb.pop_front(); checks++;
         if (obs4 !== e) begin errors++; $display("FAIL hazard_flush step %0d: got %h want %h", i, obs4, e); end
      end
      hazard = 1'b0; flush = 1'b0;
   endtask

   task automatic test_mul();
      logic [5:0] ops[5] = '{OP_MUL, OP_ADD, OP_ADD, OP_ADD, OP_ADD};
      logic hz[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      exp_t e;
      int stalls = 0;
      sb.push_back(mk(EXE_MUL, F_MS, 2'b00, 1'b1));
      sb.push_back(mk(4'h0, 8'h00, 2'b00, 1'b1));
      sb.push_back(mk(4'h0, 8'h00, 2'b00, 1'b1));
      sb.push_back(mk(EXE_MUL, F_WB, 2'b00, 1'b0));
      sb.push_back(mk(EXE_ADD, F_WB, 2'b00, 1'b0));
      for (int i = 0; i < 5; i++) begin
         opcode = ops[i]; hazard = hz[i];
         @(posedge clk); #1;
         if (obs4.stall) stalls++;
         e = sb.pop_front(); checks++;
         if (obs4 !== e) begin errors++; $display("FAIL mul4 slot %0d: got %h want %h", i, obs4, e); end
      end
      hazard = 1'b0;
      checks++;
      if (stalls != 3) begin errors++; $display("FAIL mul4_stall_cycles: got %0d want 3", stalls); end
   endtask

   task automatic test_flush_mid_mul();
      logic [5:0] ops[4] = '{OP_MUL, OP_ADD, OP_ADD, OP_SUB};
      logic fl[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      exp_t e;
      sb.push_back(mk(EXE_MUL, F_MS, 2'b00, 1'b1));
      sb.push_back(mk(4'h0, 8'h00, 2'b00, 1'b1));
      sb.push_back(mk(4'h0, 8'h00, 2'b00, 1'b0));
      sb.push_back(mk(EXE_SUB, F_WB, 2'b00, 1'b0));
      for (int i = 0; i < 4; i++) begin
         opcode = ops[i]; flush = fl[i];
         @(posedge clk); #1;
         e = sb.pop_front(); checks++;
         if (obs4 !== e) begin errors++; $display("FAIL flush_mid_mul slot %0d: got %h want %h", i, obs4, e); end
      end
      flush = 1'b0;
   endtask

   task automatic test_illegal();
      logic [5:0] ops[4] = '{6'b111111, OP_BNE, 6'b000000, OP_JMP};
      exp_t e;
      sb.push_back(mk(4'h0, F_IL, 2'b00, 1'b0));
      sb.push_back(mk(EXE_NO_OPERATION, F_BE | F_IMM | F_SB, COND_BNE, 1'b0));
      sb.push_back(mk(4'h0, F_IL, 2'b00, 1'b0));
      sb.push_back(mk(EXE_NO_OPERATION, F_BE | F_IMM, COND_JUMP, 1'b0));
      for (int i = 0; i < 4; i++) begin
         opcode = ops[i];
         @(posedge clk); #1;
         e = sb.pop_front(); checks++;
         if (obs4 !== e) begin errors++; $display("FAIL illegal step %0d: got %h want %h", i, obs4, e); end
      end
   endtask

   task automatic test_decode_table();
      logic [5:0] ops[12] = '{OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL,
                              OP_SRL, OP_SLT, OP_ADDI, OP_SUBI, OP_BEZ, OP_ADD};
      exp_t e;
      sb.push_back(mk(EXE_SUB, F_WB, 2'b00, 1'b0));
      sb.push_back(mk(EXE_AND, F_WB, 2'b00, 1'b0));
      sb.push_back(mk(EXE_OR,  F_WB, 2'b00, 1'b0));
      sb.push_back(mk(EXE_XOR, F_WB, 2'b00, 1'b0));
      sb.push_back(mk(EXE_NOR, F_WB, 2'b00, 1'b0));
      sb.push_back(mk(EXE_SLL, F_WB, 2'b00, 1'b0));
      sb.push_back(mk(EXE_SRL, F_WB, 2'b00, 1'b0));
      sb.push_back(mk(EXE_SLT, F_WB, 2'b00, 1'b0));
      sb.push_back(mk(EXE_ADD, F_WB | F_IMM, 2'b00, 1'b0));
      sb.push_back(mk(EXE_ADD, F_WB | F_IMM, 2'b00, 1'b0));
      sb.push_back(mk(EXE_NO_OPERATION, F_BE | F_IMM, COND_BEZ, 1'b0));
      sb.push_back(mk(EXE_ADD, F_WB, 2'b00, 1'b0));
      for (int i = 0; i < 12; i++) begin
         opcode = ops[i];
         @(posedge clk); #1;
         e = sb.pop_front(); checks++;
         if (obs4 !== e) begin errors++; $display("FAIL decode op %b: got %h want %h", ops[i], obs4, e); end
      end
   endtask

   task automatic test_mul_min();
      logic [5:0] ops[3] = '{OP_MUL, OP_AND, OP_AND};
      exp_t e;
      int stalls = 0;
      sb.push_back(mk(EXE_MUL, F_MS, 2'b00, 1'b1));
      sb.push_back(mk(EXE_MUL, F_WB, 2'b00, 1'b0));
      sb.push_back(mk(EXE_AND, F_WB, 2'b00, 1'b0));
      for (int i = 0; i < 3; i++) begin
         opcode = ops[i];
         @(posedge clk); #1;
         if (obs2.stall) stalls++;
         e = sb.pop_front(); checks++;
         if (obs2 !== e) begin errors++; $display("FAIL mul2 slot %0d: got %h want %h", i, obs2, e); end
      end
      checks++;
      if (stalls != 1) begin errors++; $display("FAIL mul2_stall_cycles: got %0d want 1", stalls); end
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      test_reset();
      test_hazard_flush();
      test_mul();
      test_flush_mid_mul();
      test_illegal();
      test_decode_table();
      test_mul_min();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
